// File: rtl/obj_line_pkg.sv
// Shared types for the OBJ line scanout block.
// Pixel bundle and scanout state encoding.
package obj_line_pkg;

    localparam int OBJ_LINE_PX = 240;
    localparam int OBJ_PAL_W   = 8;

    // "priority" is a reserved word, so the field is named prio
    typedef struct packed {
        logic                 opaque;
        logic                 window;
        logic [1:0]           prio;
        logic                 semitrans;
        logic [OBJ_PAL_W-1:0] palette;
    } obj_px_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT
    } scan_state_t;

endpackage

// File: rtl/obj_line_bank.sv
// One OBJ line bank: priority-resolved writes, bulk clear,
// registered read port.
import obj_line_pkg::*;

module obj_line_bank #(
    parameter int LINE_PX = OBJ_LINE_PX
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 wr_en,
    input  logic [7:0]           wr_x,
    input  logic [OBJ_PAL_W-1:0] wr_palette,
    input  logic [1:0]           wr_priority,
    input  logic                 wr_semitrans,
    input  logic                 wr_window,
    input  logic                 rd_en,
    input  logic [7:0]           rd_x,
    output obj_px_t              rd_px
);

    localparam logic [7:0] LAST_X = 8'(LINE_PX - 1);

    logic [LINE_PX-1:0]   opaque;
    logic [LINE_PX-1:0]   window;
    logic [1:0]           prio    [LINE_PX];
    logic [OBJ_PAL_W:0]   payload [LINE_PX];

    logic                 rd_opaque;
    logic                 rd_window;
    logic [1:0]           rd_prio;
    logic [OBJ_PAL_W:0]   rd_payload;

    logic                 wr_ok;
    logic                 win_set;
    logic                 col_set;

    // Equal priority keeps the stored pixel: earlier OAM index wins
    always_comb begin
        wr_ok   = wr_en && !clear && (wr_x <= LAST_X);
        win_set = wr_ok && wr_window;
        col_set = wr_ok && !wr_window &&
                  (!opaque[wr_x] || (wr_priority < prio[wr_x]));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opaque    <= '0;
            window    <= '0;
            rd_opaque <= 1'b0;
            rd_window <= 1'b0;
            rd_prio   <= 2'd3;
        end else begin
            if (clear) begin
                opaque <= '0;
                window <= '0;
            end else begin
                if (win_set) window[wr_x] <= 1'b1;
                if (col_set) opaque[wr_x] <= 1'b1;
            end
            if (rd_en) begin
                rd_opaque <= opaque[rd_x];
                rd_window <= window[rd_x];
                rd_prio   <= prio[rd_x];
            end
        end
    end

    // Payload is only meaningful where opaque is set
    always_ff @(posedge clock) begin
        if (col_set) begin
            prio[wr_x]    <= wr_priority;
            payload[wr_x] <= {wr_semitrans, wr_palette};
        end
        if (rd_en) rd_payload <= payload[rd_x];
    end

    always_comb begin
        rd_px.opaque    = rd_opaque;
        rd_px.window    = rd_window;
        rd_px.prio      = rd_prio;
        rd_px.semitrans = rd_payload[OBJ_PAL_W];
        rd_px.palette   = rd_payload[OBJ_PAL_W-1:0];
    end

endmodule

// File: rtl/obj_line_scanout.sv
// Ping-pong OBJ line buffer: renderer writes one bank while
// the other streams to the compositor over valid/ready.
import obj_line_pkg::*;

module obj_line_scanout #(
    parameter int LINE_PX = OBJ_LINE_PX,
    parameter int PAL_W   = OBJ_PAL_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             line_start,
    input  logic             wr_en,
    input  logic [7:0]       wr_x,
    input  logic [PAL_W-1:0] wr_palette,
    input  logic [1:0]       wr_priority,
    input  logic             wr_semitrans,
    input  logic             wr_window,
    output logic             px_valid,
    input  logic             px_ready,
    output logic [7:0]       px_x,
    output logic             px_opaque,
    output logic [PAL_W-1:0] px_palette,
    output logic [1:0]       px_priority,
    output logic             px_semitrans,
    output logic             px_window,
    output logic             line_done,
    output logic             scan_busy
);

    localparam logic [7:0] LAST_X = 8'(LINE_PX - 1);

    scan_state_t state;
    scan_state_t state_nx;
    logic        bank_sel;
    logic [7:0]  x;
    logic [7:0]  x_nx;
    logic        done_nx;
    logic        rd_en;
    obj_px_t     px0;
    obj_px_t     px1;
    obj_px_t     px;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bank_sel  <= 1'b0;
            x         <= '0;
            line_done <= 1'b0;
        end else begin
            state     <= state_nx;
            bank_sel  <= bank_sel ^ line_start;
            x         <= x_nx;
            line_done <= done_nx;
        end
    end

    // line_start overrides any state, aborting an unfinished scan
    always_comb begin
        state_nx = state;
        x_nx     = x;
        done_nx  = 1'b0;
        rd_en    = 1'b0;
        if (line_start) begin
            state_nx = FETCH;
            x_nx     = '0;
        end else begin
            unique case (state)
                IDLE: ;
                FETCH: begin
                    rd_en    = 1'b1;
                    state_nx = PRESENT;
                end
                PRESENT: begin
                    if (px_ready) begin
                        if (x == LAST_X) begin
                            done_nx  = 1'b1;
                            state_nx = IDLE;
                        end else begin
                            x_nx     = x + 8'd1;
                            state_nx = FETCH;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    obj_line_bank #(.LINE_PX(LINE_PX)) u_bank0 (
        .clock        (clock),
        .reset        (reset),
        .clear        (line_start & bank_sel),
        .wr_en        (wr_en & ~bank_sel),
        .wr_x         (wr_x),
        .wr_palette   (wr_palette),
        .wr_priority  (wr_priority),
        .wr_semitrans (wr_semitrans),
        .wr_window    (wr_window),
        .rd_en        (rd_en & bank_sel),
        .rd_x         (x),
        .rd_px        (px0)
    );

    obj_line_bank #(.LINE_PX(LINE_PX)) u_bank1 (
        .clock        (clock),
        .reset        (reset),
        .clear        (line_start & ~bank_sel),
        .wr_en        (wr_en & bank_sel),
        .wr_x         (wr_x),
        .wr_palette   (wr_palette),
        .wr_priority  (wr_priority),
        .wr_semitrans (wr_semitrans),
        .wr_window    (wr_window),
        .rd_en        (rd_en & ~bank_sel),
        .rd_x         (x),
        .rd_px        (px1)
    );

    always_comb px = bank_sel ? px0 : px1;

    assign px_valid     = (state == PRESENT);
    assign scan_busy    = (state != IDLE);
    assign px_x         = x;
    assign px_opaque    = px.opaque;
    assign px_palette   = px.opaque ? px.palette : '0;
    assign px_priority  = px.opaque ? px.prio : 2'd3;
    assign px_semitrans = px.opaque & px.semitrans;
    assign px_window    = px.window;

endmodule

// File: tb/tb_obj_line_scanout.sv
// Directed bench for obj_line_scanout: hand-set expected
// line contents checked pixel by pixel.
module tb_obj_line_scanout;

    localparam int NPX = 240;

    logic       clock;
    logic       reset;
    logic       line_start;
    logic       wr_en;
    logic [7:0] wr_x;
    logic [7:0] wr_palette;
    logic [1:0] wr_priority;
    logic       wr_semitrans;
    logic       wr_window;
    logic       px_valid;
    logic       px_ready;
    logic [7:0] px_x;
    logic       px_opaque;
    logic [7:0] px_palette;
    logic [1:0] px_priority;
    logic       px_semitrans;
    logic       px_window;
    logic       line_done;
    logic       scan_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic       e_op   [NPX];
    logic       e_win  [NPX];
    logic [7:0] e_pal  [NPX];
    logic [1:0] e_prio [NPX];
    logic       e_semi [NPX];

    obj_line_scanout dut (
        .clock        (clock),
        .reset        (reset),
        .line_start   (line_start),
        .wr_en        (wr_en),
        .wr_x         (wr_x),
        .wr_palette   (wr_palette),
        .wr_priority  (wr_priority),
        .wr_semitrans (wr_semitrans),
        .wr_window    (wr_window),
        .px_valid     (px_valid),
        .px_ready     (px_ready),
        .px_x         (px_x),
        .px_opaque    (px_opaque),
        .px_palette   (px_palette),
        .px_priority  (px_priority),
        .px_semitrans (px_semitrans),
        .px_window    (px_window),
        .line_done    (line_done),
        .scan_busy    (scan_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_exp();
        for (int i = 0; i < NPX; i++) begin
            e_op[i]   = 1'b0;
            e_win[i]  = 1'b0;
            e_pal[i]  = 8'h00;
            e_prio[i] = 2'd3;
            e_semi[i] = 1'b0;
        end
    endtask

    task automatic set_exp(input int x, input logic op,
                           input logic win, input logic [7:0] pal,
                           input logic [1:0] pr, input logic se);
        e_op[x]   = op;
        e_win[x]  = win;
        e_pal[x]  = pal;
        e_prio[x] = pr;
        e_semi[x] = se;
    endtask

    task automatic drive_wr(input logic [7:0] x, input logic [7:0] pal,
                            input logic [1:0] pr, input logic se,
                            input logic win);
        wr_en        = 1'b1;
        wr_x         = x;
        wr_palette   = pal;
        wr_priority  = pr;
        wr_semitrans = se;
        wr_window    = win;
    endtask

    task automatic wr(input logic [7:0] x, input logic [7:0] pal,
                      input logic [1:0] pr, input logic se,
                      input logic win);
        drive_wr(x, pal, pr, se, win);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_line(input logic with_wr);
        line_start = 1'b1;
        if (with_wr) drive_wr(8'd5, 8'h55, 2'd0, 1'b1, 1'b0);
        tick();
        line_start = 1'b0;
        wr_en      = 1'b0;
        check("start_valid", px_valid, 1'b0);
        check("start_busy", scan_busy, 1'b1);
    endtask

    task automatic scan(input int hold_x, input int stop_x);
        for (int x = 0; x < NPX; x++) begin
            int n = 0;
            while (!px_valid && n < 8) begin
                tick();
                n++;
            end
            if (!px_valid) begin
                check("valid_timeout", px_valid, 1'b1);
                return;
            end
            if (x == 0) check("first_latency", n, 1);
            check("px_x", px_x, x);
            check("px_opaque", px_opaque, e_op[x]);
            check("px_palette", px_palette, e_pal[x]);
            check("px_priority", px_priority, e_prio[x]);
            check("px_semitrans", px_semitrans, e_semi[x]);
            check("px_window", px_window, e_win[x]);
            check("done_early", line_done, 1'b0);
            if (x == stop_x) return;
            if (x == hold_x) begin
                for (int k = 0; k < 5; k++) begin
                    tick();
                    check("hold_valid", px_valid, 1'b1);
                    check("hold_x", px_x, x);
                    check("hold_pal", px_palette, e_pal[x]);
                end
            end
            px_ready = 1'b1;
            tick();
            px_ready = 1'b0;
        end
        check("line_done", line_done, 1'b1);
        tick();
        check("done_pulse", line_done, 1'b0);
        check("idle_valid", px_valid, 1'b0);
        check("idle_busy", scan_busy, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", px_valid, 1'b0);
        check("rst_x", px_x, 8'd0);
        check("rst_opaque", px_opaque, 1'b0);
        check("rst_pal", px_palette, 8'h00);
        check("rst_prio", px_priority, 2'd3);
        check("rst_semi", px_semitrans, 1'b0);
        check("rst_win", px_window, 1'b0);
        check("rst_done", line_done, 1'b0);
        check("rst_busy", scan_busy, 1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        line_start   = 1'b0;
        wr_en        = 1'b0;
        wr_x         = 8'd0;
        wr_palette   = 8'h00;
        wr_priority  = 2'd0;
        wr_semitrans = 1'b0;
        wr_window    = 1'b0;
        px_ready     = 1'b0;
        tick();
        tick();
        check_reset_outputs();
        reset = 1'b0;
        tick();
        check_reset_outputs();

        // line 1: nothing written
        clr_exp();
        start_line(1'b0);
        scan(-1, NPX);

        // line 2 contents: priority, window, out-of-range write
        wr(8'd10, 8'h35, 2'd2, 1'b1, 1'b0);
        wr(8'd10, 8'h7A, 2'd1, 1'b0, 1'b0);
        wr(8'd10, 8'h11, 2'd1, 1'b1, 1'b0);
        wr(8'd20, 8'hC3, 2'd0, 1'b1, 1'b1);
        wr(8'd20, 8'h42, 2'd0, 1'b0, 1'b0);
        wr(8'd21, 8'hE7, 2'd2, 1'b1, 1'b1);
        wr(8'd240, 8'hFF, 2'd0, 1'b1, 1'b0);
        wr(8'd255, 8'hEE, 2'd0, 1'b1, 1'b1);
        clr_exp();
        set_exp(5, 1'b1, 1'b0, 8'h55, 2'd0, 1'b1);
        set_exp(10, 1'b1, 1'b0, 8'h7A, 2'd1, 1'b0);
        set_exp(20, 1'b1, 1'b1, 8'h42, 2'd0, 1'b0);
        set_exp(21, 1'b0, 1'b1, 8'h00, 2'd3, 1'b0);
        start_line(1'b1);
        scan(3, NPX);

        // line 3: only the post-swap write, old pixels gone
        wr(8'd7, 8'h66, 2'd3, 1'b0, 1'b0);
        clr_exp();
        set_exp(7, 1'b1, 1'b0, 8'h66, 2'd3, 1'b0);
        start_line(1'b0);
        scan(-1, NPX);

        // line 4: aborted at x=100
        wr(8'd100, 8'h99, 2'd0, 1'b0, 1'b0);
        wr(8'd150, 8'h77, 2'd2, 1'b1, 1'b0);
        clr_exp();
        set_exp(100, 1'b1, 1'b0, 8'h99, 2'd0, 1'b0);
        set_exp(150, 1'b1, 1'b0, 8'h77, 2'd2, 1'b1);
        start_line(1'b0);
        scan(-1, 100);
        check("abort_busy", scan_busy, 1'b1);

        // line 5: restart on the other, clean bank
        clr_exp();
        start_line(1'b0);
        check("abort_no_done", line_done, 1'b0);
        scan(-1, NPX);

        // line 6: aborted bank was cleared, only rewrite shows
        wr(8'd150, 8'h12, 2'd1, 1'b0, 1'b0);
        clr_exp();
        set_exp(150, 1'b1, 1'b0, 8'h12, 2'd1, 1'b0);
        start_line(1'b0);
        scan(-1, NPX);

        // line 7: reset mid-scan
        wr(8'd2, 8'hA5, 2'd1, 1'b1, 1'b0);
        clr_exp();
        set_exp(2, 1'b1, 1'b0, 8'hA5, 2'd1, 1'b1);
        start_line(1'b0);
        scan(-1, 2);
        reset = 1'b1;
        #1;
        check_reset_outputs();
        tick();
        reset = 1'b0;
        tick();
        check_reset_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
